irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl_if.sv | 24 ++
 rtl/irq_ctrl.sv | 123 ++++++++++++
 tb/tb_irq_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_if.sv
// ============================================================================
// Module      : irq_ctrl_if
// Description : Register bus between the CPU bridge and the interrupt
//               controller.
//               addr [3:2] : word select (0=MASK, 1=PEND, 2=MODE, 3=ID)
//               we         : write strobe, qualified by addr and wd
//               wd   [31:0]: write data
//               rd   [31:0]: combinational read data for addr
//               master = bridge side, slave = controller side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface irq_ctrl_if;
  logic [3:2]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output addr, output we, output wd, input rd);
  modport slave  (input addr, input we, input wd, output rd);
endinterface

`default_nettype wire

// File: rtl/irq_ctrl.sv
// ============================================================================
// Module      : irq_ctrl
// Description : Six-source interrupt controller with per-source mask and
//               level/rising-edge mode, write-1-to-clear pending bits in
//               edge mode, and registered CPU interrupt lines.
//               Optional macro IRQ_CTRL_PRIO_EN: hwint becomes one-hot on the
//               lowest-index active source and ID reports that source.
// Ports       : clk     - system clock, rising edge
//               rst     - synchronous active-high reset
//               bus     - register bus (irq_ctrl_if.slave)
//               irq_src - asynchronous interrupt lines, bit 0 highest priority
//               hwint   - registered CPU interrupt lines, hwint[i+2] = src i
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_ctrl (
  input  wire logic       clk,
  input  wire logic       rst,
  irq_ctrl_if.slave       bus,
  input  wire logic [5:0] irq_src,
  output logic      [7:2] hwint
);

  localparam logic [1:0] C_ADDR_MASK = 2'd0;
  localparam logic [1:0] C_ADDR_PEND = 2'd1;
  localparam logic [1:0] C_ADDR_MODE = 2'd2;

  logic [5:0] r_s1;
  logic [5:0] r_s2;
  logic [5:0] r_s2_d;   // previous s2, used for rising-edge detection
  logic [5:0] r_mask;
  logic [5:0] r_mode;
  logic [5:0] r_pend;
  logic [5:0] r_hwint;

  logic        w_wr_mask;
  logic        w_wr_pend;
  logic        w_wr_mode;
  logic [5:0]  w_rise;
  logic [5:0]  w_w1c;
  logic [5:0]  w_mode_chg;
  logic [5:0]  w_pend_nxt;
  logic [5:0]  w_act;
  logic [5:0]  w_hw_nxt;
  logic [31:0] w_id;
  logic        w_unused;

  assign w_wr_mask = bus.we && (bus.addr == C_ADDR_MASK);
  assign w_wr_pend = bus.we && (bus.addr == C_ADDR_PEND);
  assign w_wr_mode = bus.we && (bus.addr == C_ADDR_MODE);

  assign w_rise     = r_s2 & ~r_s2_d;
  assign w_w1c      = w_wr_pend ? bus.wd[5:0] : 6'h00;
  assign w_mode_chg = w_wr_mode ? (bus.wd[5:0] ^ r_mode) : 6'h00;

  // Edge bits: a fresh edge beats a simultaneous W1C. Level bits follow s2.
  // A mode change on a bit wipes its pending state for this cycle.
  assign w_pend_nxt = ((r_mode & (w_rise | (r_pend & ~w_w1c))) |
                       (~r_mode & r_s2)) & ~w_mode_chg;

  assign w_act = r_pend & r_mask;

`ifdef IRQ_CTRL_PRIO_EN
  logic [2:0] w_idx;

  // Scan from the lowest priority upward so the last hit is the winner.
  always_comb begin
    w_hw_nxt = 6'h00;
    w_idx    = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (w_act[i]) begin
        w_hw_nxt    = 6'h00;
        w_hw_nxt[i] = 1'b1;
        w_idx       = i[2:0];
      end
    end
  end

  assign w_id = {(|w_act), 28'd0, w_idx};
`else
  assign w_hw_nxt = w_act;
  assign w_id     = 32'h0;
`endif

  always_comb begin
    bus.rd = 32'h0;
    case (bus.addr)
      2'd0:    bus.rd = {26'd0, r_mask};
      2'd1:    bus.rd = {26'd0, r_pend};
      2'd2:    bus.rd = {26'd0, r_mode};
      default: bus.rd = w_id;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 6'h00;
      r_s2    <= 6'h00;
      r_s2_d  <= 6'h00;
      r_mask  <= 6'h00;
      r_mode  <= 6'h00;
      r_pend  <= 6'h00;
      r_hwint <= 6'h00;
    end else begin
      r_s1    <= irq_src;
      r_s2    <= r_s1;
      r_s2_d  <= r_s2;
      r_pend  <= w_pend_nxt;
      r_hwint <= w_hw_nxt;
      if (w_wr_mask) r_mask <= bus.wd[5:0];
      if (w_wr_mode) r_mode <= bus.wd[5:0];
    end
  end

  assign hwint = r_hwint;

  // Upper write-data bits have no destination.
  assign w_unused = ^bus.wd[31:6];

endmodule

`default_nettype wire

// File: tb/tb_irq_ctrl.sv
// ============================================================================
// Module      : tb_irq_ctrl
// Description : Self-checking bench for irq_ctrl. A behavioural model tracks
//               the register state from the per-source rules; a compare
//               process checks hwint and rd against it every cycle, while
//               directed sequences pin the model with literal values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] irq_src = 6'h00;
  logic [7:2] hwint;

  irq_ctrl_if bus ();

  irq_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .irq_src (irq_src),
    .hwint   (hwint)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [5:0] m_mask = 6'h00;
  logic [5:0] m_mode = 6'h00;
  logic [5:0] m_pend = 6'h00;
  logic [5:0] m_hw   = 6'h00;
  logic [5:0] m_hist [3];   // irq_src sampled 1, 2 and 3 edges ago
  bit         m_ok   = 1'b0;

  // Lowest set bit via two's complement isolation.
  function automatic logic [5:0] lowbit(input logic [5:0] x);
    return x & (~x + 6'd1);
  endfunction

  function automatic logic [5:0] hw_of(input logic [5:0] act);
`ifdef IRQ_CTRL_PRIO_EN
    return lowbit(act);
`else
    return act;
`endif
  endfunction

  function automatic logic [31:0] id_of(input logic [5:0] act);
`ifdef IRQ_CTRL_PRIO_EN
    logic [5:0] b;
    int idx;
    b = lowbit(act);
    if (b == 6'h00) return 32'h0;
    idx = $clog2(b);
    return 32'h8000_0000 | idx;
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [31:0] m_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {26'd0, m_mask};
      2'd1:    return {26'd0, m_pend};
      2'd2:    return {26'd0, m_mode};
      default: return id_of(m_pend & m_mask);
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mask = 0; m_mode = 0; m_pend = 0; m_hw = 0;
      for (int i = 0; i < 3; i++) m_hist[i] = 0;
      m_ok = 1'b1;
    end else begin
      logic [5:0] np;
      logic [5:0] s2, prev;
      s2   = m_hist[1];
      prev = m_hist[2];
      for (int i = 0; i < 6; i++) begin
        if (!m_mode[i]) begin
          np[i] = s2[i];
        end else if (s2[i] && !prev[i]) begin
          np[i] = 1'b1;
        end else if (bus.we && bus.addr == 2'd1 && bus.wd[i]) begin
          np[i] = 1'b0;
        end else begin
          np[i] = m_pend[i];
        end
        if (bus.we && bus.addr == 2'd2 && bus.wd[i] != m_mode[i]) np[i] = 1'b0;
      end
      m_hw = hw_of(m_pend & m_mask);
      m_pend = np;
      if (bus.we && bus.addr == 2'd0) m_mask = bus.wd[5:0];
      if (bus.we && bus.addr == 2'd2) m_mode = bus.wd[5:0];
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = irq_src;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("hwint_vs_model", {26'd0, hwint}, {26'd0, m_hw});
      chk("rd_vs_model", bus.rd, m_rd(bus.addr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.we = 1'b1; bus.addr = a; bus.wd = d;
    tick();
    bus.we = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    chk(name, bus.rd, exp);
  endtask

  initial begin
    bus.addr = 2'd0;
    bus.we   = 1'b1;
    bus.wd   = 32'hFFFF_FFFF;
    irq_src  = 6'h3F;
    rst      = 1'b1;
    repeat (3) tick();
    for (int a = 0; a < 4; a++) rd_chk("reset_reg", a[1:0], 32'h0);
    chk("reset_hwint", {26'd0, hwint}, 32'h0);
    rst = 1'b0; bus.we = 1'b0; irq_src = 6'h00; bus.wd = 32'h0;

    // Level latency; first write lands on the first edge out of reset.
    wr(2'd0, 32'h01);
    rd_chk("first_write_mask", 2'd0, 32'h01);
    wr(2'd2, 32'h00);
    repeat (4) tick();
    bus.addr = 2'd1;
    irq_src = 6'h01;
    tick();                                   // edge k
    chk("lvl_pend_k", bus.rd, 32'h0);
    tick();                                   // k+1
    chk("lvl_pend_k1", bus.rd, 32'h0);
    tick();                                   // k+2
    chk("lvl_pend_k2", bus.rd, 32'h01);
    chk("lvl_hw_k2", {26'd0, hwint}, 32'h0);
    tick();                                   // k+3
    chk("lvl_hw_k3", {26'd0, hwint}, 32'h01);
    irq_src = 6'h00;
    repeat (3) tick();
    chk("lvl_hw_hold", {26'd0, hwint}, 32'h01);
    tick();
    chk("lvl_hw_clear", {26'd0, hwint}, 32'h0);

    // Edge mode, W1C collision.
    wr(2'd2, 32'h04);
    wr(2'd0, 32'h04);
    bus.addr = 2'd1;
    irq_src = 6'h04; tick();
    irq_src = 6'h00; repeat (2) tick();
    chk("edge_pend_set", bus.rd, 32'h04);
    repeat (3) tick();
    chk("edge_sticky", bus.rd, 32'h04);
    irq_src = 6'h04; tick();
    irq_src = 6'h00; tick();
    wr(2'd1, 32'h4);                          // coincides with new edge
    chk("edge_collision", bus.rd, 32'h04);
    tick();
    wr(2'd1, 32'h4);
    chk("edge_w1c", bus.rd, 32'h0);

    // Masking.
    wr(2'd2, 32'h30);
    wr(2'd0, 32'h00);
    irq_src = 6'h30; tick();
    irq_src = 6'h00; repeat (4) tick();
    rd_chk("mask_pend", 2'd1, 32'h30);
    chk("mask_hw_off", {26'd0, hwint}, 32'h0);
    wr(2'd0, 32'h20);
    chk("mask_hw_wait", {26'd0, hwint}, 32'h0);
    tick();
    chk("mask_hw_on", {26'd0, hwint}, 32'h20);

    // Priority / plain active set.
    wr(2'd2, 32'h2C);
    wr(2'd0, 32'h2C);
    irq_src = 6'h0C; tick();
    irq_src = 6'h00; repeat (4) tick();
    rd_chk("prio_pend", 2'd1, 32'h2C);
    bus.addr = 2'd3;
`ifdef IRQ_CTRL_PRIO_EN
    #1 chk("prio_id_a", bus.rd, 32'h8000_0002);
    chk("prio_hw_a", {26'd0, hwint}, 32'h04);
    wr(2'd1, 32'h4);
    bus.addr = 2'd3;
    #1 chk("prio_id_b", bus.rd, 32'h8000_0003);
    tick();
    chk("prio_hw_b", {26'd0, hwint}, 32'h08);
`else
    #1 chk("prio_id_a", bus.rd, 32'h0);
    chk("prio_hw_a", {26'd0, hwint}, 32'h2C);
    wr(2'd1, 32'h4);
    bus.addr = 2'd3;
    #1 chk("prio_id_b", bus.rd, 32'h0);
    tick();
    chk("prio_hw_b", {26'd0, hwint}, 32'h28);
`endif
    wr(2'd3, 32'hFFFF_FFFF);
    rd_chk("id_write_ignored", 2'd0, 32'h2C);

    // Randomized traffic, checked every cycle by the compare process.
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 199) == 0);
      bus.we   = ($urandom_range(0, 3) == 0);
      bus.addr = 2'($urandom_range(0, 3));
      bus.wd   = $urandom;
      if ($urandom_range(0, 3) == 0) irq_src = 6'($urandom);
      tick();
    end
    rst = 1'b0; bus.we = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
